// File: rtl/way_select_decoder.sv
// Binary way index to registered one-hot read/write enables for the L2 arrays.
// Each accepted request holds its enable for a fixed window, then pulses done.
module way_select_decoder #(
    parameter int WAYS          = 8,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [$clog2(WAYS)-1:0]   req_way,
    input  logic                      req_write,
    output logic [WAYS-1:0]           way_rd_en,
    output logic [WAYS-1:0]           way_wr_en,
    output logic                      done,
    output logic                      err
);
    localparam int IW = $clog2(WAYS);
    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(ACCESS_CYCLES - 1);
    localparam logic [IW:0]   WAYS_L   = (IW + 1)'(WAYS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [CW-1:0]     cnt_r, cnt_s;
    logic [IW-1:0]     way_r, way_s;
    logic              write_r, write_s;
    logic [WAYS-1:0]   rd_en_r, rd_en_s;
    logic [WAYS-1:0]   wr_en_r, wr_en_s;
    logic              done_r, done_s;
    logic              err_r, err_s;
    logic              accept_s;
    logic              in_range_s;

    function automatic logic [WAYS-1:0] onehot(input logic [IW-1:0] idx);
        return {{(WAYS-1){1'b0}}, 1'b1} << idx;
    endfunction

    assign req_ready  = (state_r != ACTIVE);
    assign accept_s   = req_valid && req_ready;
    assign in_range_s = ({1'b0, req_way} < WAYS_L);

    assign way_rd_en = rd_en_r;
    assign way_wr_en = wr_en_r;
    assign done      = done_r;
    assign err       = err_r;

    // Next-state, counter, request latch and pulse decode.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        way_s   = way_r;
        write_s = write_r;
        done_s  = 1'b0;
        err_s   = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (accept_s && in_range_s) begin
                    state_s = ACTIVE;
                    cnt_s   = CNT_LOAD;
                    way_s   = req_way;
                    write_s = req_write;
                end else if (accept_s) begin
                    state_s = IDLE;
                    err_s   = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            ACTIVE: begin
                if (cnt_r != {CW{1'b0}}) begin
                    cnt_s = cnt_r - CW'(1);
                end else begin
                    state_s = DONE;
                    done_s  = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CW{1'b0}};
            end
        endcase
    end

    // Enables are computed from the next state so the registered copy lines up with ACTIVE.
    always_comb begin
        rd_en_s = {WAYS{1'b0}};
        wr_en_s = {WAYS{1'b0}};
        if (state_s == ACTIVE) begin
            if (write_s) begin
                wr_en_s = onehot(way_s);
            end else begin
                rd_en_s = onehot(way_s);
            end
        end else begin
            rd_en_s = {WAYS{1'b0}};
            wr_en_s = {WAYS{1'b0}};
        end
    end

    // State and output registers; reset abandons any window in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            way_r   <= {IW{1'b0}};
            write_r <= 1'b0;
            rd_en_r <= {WAYS{1'b0}};
            wr_en_r <= {WAYS{1'b0}};
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            way_r   <= way_s;
            write_r <= write_s;
            rd_en_r <= rd_en_s;
            wr_en_r <= wr_en_s;
            done_r  <= done_s;
            err_r   <= err_s;
        end
    end

    way_select_decoder_chk #(
        .WAYS          (WAYS),
        .CW            (CW),
        .ACCESS_CYCLES (ACCESS_CYCLES)
    ) u_chk (
        .clk    (clk),
        .rst_n  (rst_n),
        .active (state_r == ACTIVE),
        .rd_en  (rd_en_r),
        .wr_en  (wr_en_r),
        .cnt    (cnt_r),
        .done   (done_r),
        .err    (err_r)
    );

endmodule

// Invariant checker for way_select_decoder.
module way_select_decoder_chk #(
    parameter int WAYS          = 8,
    parameter int CW            = 1,
    parameter int ACCESS_CYCLES = 2
) (
    input logic            clk,
    input logic            rst_n,
    input logic            active,
    input logic [WAYS-1:0] rd_en,
    input logic [WAYS-1:0] wr_en,
    input logic [CW-1:0]   cnt,
    input logic            done,
    input logic            err
);
    localparam logic [CW-1:0] CNT_MAX = CW'(ACCESS_CYCLES - 1);

    a_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({rd_en, wr_en}));

    a_quiet: assert property (@(posedge clk) disable iff (!rst_n)
        !active |-> (rd_en == {WAYS{1'b0}}) && (wr_en == {WAYS{1'b0}}));

    a_cnt: assert property (@(posedge clk) disable iff (!rst_n)
        cnt <= CNT_MAX);

    a_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(done && err));

endmodule

// File: tb/tb_way_select_decoder.sv
// Random and directed bench for way_select_decoder: an 8-way/2-cycle and a 6-way/1-cycle
// instance share inputs and are each checked against a timeline reference model.
module tb_way_select_decoder;

    typedef struct packed {
        logic       err;
        logic       done;
        logic [7:0] wr;
        logic [7:0] rd;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic [2:0] req_way;
    logic       req_write;

    logic       rdy_a, done_a, err_a;
    logic [7:0] rd_a, wr_a;
    logic       rdy_b, done_b, err_b;
    logic [5:0] rd_b, wr_b;

    int   checks = 0;
    int   errors = 0;
    exp_t cur [2];
    exp_t q0 [$];
    exp_t q1 [$];

    always #5 clk = ~clk;

    way_select_decoder #(.WAYS(8), .ACCESS_CYCLES(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_a),
        .req_way(req_way), .req_write(req_write), .way_rd_en(rd_a),
        .way_wr_en(wr_a), .done(done_a), .err(err_a)
    );

    way_select_decoder #(.WAYS(6), .ACCESS_CYCLES(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_b),
        .req_way(req_way), .req_write(req_write), .way_rd_en(rd_b),
        .way_wr_en(wr_b), .done(done_b), .err(err_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // A request seen as accepted schedules its whole future output timeline.
    task automatic plan(input int d);
        exp_t e;
        int   ways;
        int   ac;
        logic rdy;
        ways = (d == 0) ? 8 : 6;
        ac   = (d == 0) ? 2 : 1;
        rdy  = (cur[d].rd == 8'h00) && (cur[d].wr == 8'h00);
        if (req_valid && rdy) begin
            e = '0;
            if (int'(req_way) < ways) begin
                if (req_write) e.wr = 8'(1) << req_way;
                else           e.rd = 8'(1) << req_way;
                for (int k = 0; k < ac; k++) push(d, e);
                e = '0;
                e.done = 1'b1;
                push(d, e);
            end else begin
                e.err = 1'b1;
                push(d, e);
            end
        end
    endtask

    task automatic model_reset();
        cur[0] = '0;
        cur[1] = '0;
        q0.delete();
        q1.delete();
    endtask

    task automatic compare();
        check_eq("ready_a", 32'(rdy_a), 32'((cur[0].rd == 8'h00) && (cur[0].wr == 8'h00)));
        check_eq("rd_a",    32'(rd_a),  32'(cur[0].rd));
        check_eq("wr_a",    32'(wr_a),  32'(cur[0].wr));
        check_eq("done_a",  32'(done_a), 32'(cur[0].done));
        check_eq("err_a",   32'(err_a), 32'(cur[0].err));
        check_eq("ready_b", 32'(rdy_b), 32'((cur[1].rd == 8'h00) && (cur[1].wr == 8'h00)));
        check_eq("rd_b",    32'(rd_b),  32'(cur[1].rd));
        check_eq("wr_b",    32'(wr_b),  32'(cur[1].wr));
        check_eq("done_b",  32'(done_b), 32'(cur[1].done));
        check_eq("err_b",   32'(err_b), 32'(cur[1].err));
    endtask

    task automatic cycle();
        plan(0);
        plan(1);
        @(posedge clk);
        #1;
        if (q0.size() > 0) cur[0] = q0.pop_front(); else cur[0] = '0;
        if (q1.size() > 0) cur[1] = q1.pop_front(); else cur[1] = '0;
        compare();
    endtask

    task automatic drive(input logic v, input logic [2:0] w, input logic wr);
        req_valid = v;
        req_way   = w;
        req_write = wr;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 3'd0, 1'b0);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst_n = 1'b1;
        drive(1'b0, 3'd0, 1'b0);
        model_reset();
        #2 rst_n = 1'b0;
        #1 compare();
        check_eq("reset_ready", 32'(rdy_a), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        idle(2);

        // Read of way 5 on the 8-way instance.
        drive(1'b1, 3'd5, 1'b0);
        cycle();
        check_eq("rd5_t1", 32'(rd_a), 32'h20);
        check_eq("rd5_rdy", 32'(rdy_a), 32'd0);
        drive(1'b0, 3'd0, 1'b0);
        cycle();
        check_eq("rd5_t2", 32'(rd_a), 32'h20);
        cycle();
        check_eq("rd5_done", 32'(done_a), 32'd1);
        cycle();
        check_eq("rd5_done_once", 32'(done_a), 32'd0);
        idle(2);

        // Back-to-back writes, the second accepted in the DONE cycle.
        drive(1'b1, 3'd0, 1'b1);
        cycle();
        check_eq("wr0_t1", 32'(wr_a), 32'h01);
        drive(1'b1, 3'd7, 1'b1);
        cycle();
        check_eq("wr0_t2", 32'(wr_a), 32'h01);
        cycle();
        check_eq("wr0_done", 32'(done_a), 32'd1);
        cycle();
        check_eq("wr7_t4", 32'(wr_a), 32'h80);
        drive(1'b0, 3'd0, 1'b0);
        cycle();
        check_eq("wr7_t5", 32'(wr_a), 32'h80);
        cycle();
        check_eq("wr7_done", 32'(done_a), 32'd1);
        idle(3);

        // Out-of-range index on the 6-way instance.
        drive(1'b1, 3'd6, 1'b0);
        cycle();
        check_eq("oor_err", 32'(err_b), 32'd1);
        check_eq("oor_rdy", 32'(rdy_b), 32'd1);
        drive(1'b0, 3'd0, 1'b0);
        cycle();
        check_eq("oor_err_once", 32'(err_b), 32'd0);
        idle(3);

        // Single-cycle windows back to back on the 6-way instance.
        drive(1'b1, 3'd1, 1'b0);
        cycle();
        check_eq("ac1_w1", 32'(rd_b), 32'h02);
        drive(1'b1, 3'd2, 1'b0);
        cycle();
        check_eq("ac1_gap1", 32'(rd_b), 32'h00);
        check_eq("ac1_done1", 32'(done_b), 32'd1);
        cycle();
        check_eq("ac1_w2", 32'(rd_b), 32'h04);
        drive(1'b1, 3'd3, 1'b0);
        cycle();
        check_eq("ac1_gap2", 32'(rd_b), 32'h00);
        cycle();
        check_eq("ac1_w3", 32'(rd_b), 32'h08);
        idle(3);

        // Reset in the middle of an access window.
        drive(1'b1, 3'd4, 1'b0);
        cycle();
        drive(1'b0, 3'd0, 1'b0);
        #2 rst_n = 1'b0;
        model_reset();
        #1 compare();
        check_eq("mid_rst_rd", 32'(rd_a), 32'h00);
        @(negedge clk) rst_n = 1'b1;
        idle(4);
        check_eq("post_rst_rdy", 32'(rdy_a), 32'd1);
        drive(1'b1, 3'd2, 1'b0);
        cycle();
        check_eq("post_rst_rd2", 32'(rd_a), 32'h04);
        idle(3);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            cycle();
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
